// File: rtl/axi_read_arbiter.sv
// Read-channel controller for a 2x2 AXI interconnect: round-robin AR arbitration,
// address decode to S0/S1/default slave, and the read-state code consumed by the S2M mux.
module axi_read_arbiter #(
  parameter logic [15:0] S0_BASE = 16'h0000,
  parameter logic [15:0] S1_BASE = 16'h0001
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        ARVALID_M0,
  input  logic        ARVALID_M1,
  input  logic [31:0] ARADDR_M0,
  input  logic [31:0] ARADDR_M1,
  input  logic [3:0]  ARID_M0,
  input  logic [3:0]  ARID_M1,
  input  logic [3:0]  ARLEN_M0,
  input  logic [3:0]  ARLEN_M1,
  output logic        ARREADY_M0,
  output logic        ARREADY_M1,
  output logic        ARVALID_S0,
  output logic        ARVALID_S1,
  input  logic        ARREADY_S0,
  input  logic        ARREADY_S1,
  input  logic        RVALID_S0,
  input  logic        RVALID_S1,
  input  logic        RLAST_S0,
  input  logic        RLAST_S1,
  input  logic        RREADY_M0,
  input  logic        RREADY_M1,
  output logic        RREADY_S0,
  output logic        RREADY_S1,
  output logic [3:0]  CS_R,
  output logic [3:0]  NS_R,
  output logic [7:0]  DEF_RID,
  output logic [1:0]  DEF_RRESP,
  output logic        DEF_RVALID,
  output logic        DEF_RLAST
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RA_M1   = 4'd1,
    RD_M1S0 = 4'd2,
    RD_M1S1 = 4'd3,
    RA_M0   = 4'd4,
    RD_M0S0 = 4'd5,
    RD_M0S1 = 4'd6,
    DEF_SLV = 4'd13
  } state_t;

  state_t      cs, ns;
  logic        last_grant;   // 0 = M0, 1 = M1
  logic [3:0]  cnt;
  logic [3:0]  lat_len;
  logic [3:0]  lat_id;
  logic        lat_mst;

  logic        def_take;
  logic [3:0]  sel_id;
  logic [3:0]  sel_len;
  logic        sel_mst;
  logic        done;
  logic        done_mst;
  logic        def_rdy;
  logic        def_last;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{ARADDR_M0[15:0], ARADDR_M1[15:0]};

  assign def_rdy  = lat_mst ? RREADY_M1 : RREADY_M0;
  assign def_last = (cnt == lat_len);

  always_comb begin
    ns          = cs;
    ARREADY_M0  = 1'b0;
    ARREADY_M1  = 1'b0;
    ARVALID_S0  = 1'b0;
    ARVALID_S1  = 1'b0;
    RREADY_S0   = 1'b0;
    RREADY_S1   = 1'b0;
    def_take    = 1'b0;
    sel_id      = ARID_M0;
    sel_len     = ARLEN_M0;
    sel_mst     = 1'b0;
    done        = 1'b0;
    done_mst    = 1'b0;
    case (cs)
      IDLE: begin
        if (ARVALID_M0 && ARVALID_M1) ns = last_grant ? RA_M0 : RA_M1;
        else if (ARVALID_M0)          ns = RA_M0;
        else if (ARVALID_M1)          ns = RA_M1;
      end
      RA_M0: begin
        if (!ARVALID_M0) begin
          ns = IDLE;
        end else if (ARADDR_M0[31:16] == S0_BASE) begin
          ARVALID_S0 = 1'b1;
          ARREADY_M0 = ARREADY_S0;
          if (ARREADY_S0) ns = RD_M0S0;
        end else if (ARADDR_M0[31:16] == S1_BASE) begin
          ARVALID_S1 = 1'b1;
          ARREADY_M0 = ARREADY_S1;
          if (ARREADY_S1) ns = RD_M0S1;
        end else begin
          // Unmapped: the arbiter itself accepts the address as default slave.
          ARREADY_M0 = 1'b1;
          def_take   = 1'b1;
          ns         = DEF_SLV;
        end
      end
      RA_M1: begin
        sel_id  = ARID_M1;
        sel_len = ARLEN_M1;
        sel_mst = 1'b1;
        if (!ARVALID_M1) begin
          ns = IDLE;
        end else if (ARADDR_M1[31:16] == S0_BASE) begin
          ARVALID_S0 = 1'b1;
          ARREADY_M1 = ARREADY_S0;
          if (ARREADY_S0) ns = RD_M1S0;
        end else if (ARADDR_M1[31:16] == S1_BASE) begin
          ARVALID_S1 = 1'b1;
          ARREADY_M1 = ARREADY_S1;
          if (ARREADY_S1) ns = RD_M1S1;
        end else begin
          ARREADY_M1 = 1'b1;
          def_take   = 1'b1;
          ns         = DEF_SLV;
        end
      end
      RD_M0S0: begin
        RREADY_S0 = RREADY_M0;
        if (RVALID_S0 && RREADY_M0 && RLAST_S0) begin
          ns   = IDLE;
          done = 1'b1;
        end
      end
      RD_M0S1: begin
        RREADY_S1 = RREADY_M0;
        if (RVALID_S1 && RREADY_M0 && RLAST_S1) begin
          ns   = IDLE;
          done = 1'b1;
        end
      end
      RD_M1S0: begin
        RREADY_S0 = RREADY_M1;
        if (RVALID_S0 && RREADY_M1 && RLAST_S0) begin
          ns       = IDLE;
          done     = 1'b1;
          done_mst = 1'b1;
        end
      end
      RD_M1S1: begin
        RREADY_S1 = RREADY_M1;
        if (RVALID_S1 && RREADY_M1 && RLAST_S1) begin
          ns       = IDLE;
          done     = 1'b1;
          done_mst = 1'b1;
        end
      end
      DEF_SLV: begin
        if (def_rdy && def_last) begin
          ns       = IDLE;
          done     = 1'b1;
          done_mst = lat_mst;
        end
      end
      default: ns = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cs         <= IDLE;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      lat_len    <= 4'd0;
      lat_id     <= 4'd0;
      lat_mst    <= 1'b0;
    end else begin
      cs <= ns;
      if (done) last_grant <= done_mst;
      if (def_take) begin
        lat_id  <= sel_id;
        lat_len <= sel_len;
        lat_mst <= sel_mst;
        cnt     <= 4'd0;
      end else if (cs == DEF_SLV && def_rdy && !def_last) begin
        // Held at ARLEN on the final beat so a 16-beat burst never wraps.
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign CS_R       = cs;
  assign NS_R       = ns;
  assign DEF_RVALID = (cs == DEF_SLV);
  assign DEF_RLAST  = DEF_RVALID && def_last;
  assign DEF_RRESP  = DEF_RVALID ? 2'b11 : 2'b00;
  assign DEF_RID    = {3'b000, lat_mst, lat_id};

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: directed scenarios plus randomized
// transactions predicted from a transaction-level round-robin/decode model.
module tb_axi_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        ARVALID_M0, ARVALID_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [3:0]  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1;
  logic        ARREADY_M0, ARREADY_M1, ARVALID_S0, ARVALID_S1;
  logic        ARREADY_S0, ARREADY_S1;
  logic        RVALID_S0, RVALID_S1, RLAST_S0, RLAST_S1;
  logic        RREADY_M0, RREADY_M1, RREADY_S0, RREADY_S1;
  logic [3:0]  CS_R, NS_R;
  logic [7:0]  DEF_RID;
  logic [1:0]  DEF_RRESP;
  logic        DEF_RVALID, DEF_RLAST;

  int checks   = 0;
  int failures = 0;

  localparam logic [15:0] S0B = 16'h0000;
  localparam logic [15:0] S1B = 16'h0001;

  always #5 ACLK = ~ACLK;

  axi_read_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
    .ARADDR_M0(ARADDR_M0), .ARADDR_M1(ARADDR_M1),
    .ARID_M0(ARID_M0), .ARID_M1(ARID_M1),
    .ARLEN_M0(ARLEN_M0), .ARLEN_M1(ARLEN_M1),
    .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1),
    .ARVALID_S0(ARVALID_S0), .ARVALID_S1(ARVALID_S1),
    .ARREADY_S0(ARREADY_S0), .ARREADY_S1(ARREADY_S1),
    .RVALID_S0(RVALID_S0), .RVALID_S1(RVALID_S1),
    .RLAST_S0(RLAST_S0), .RLAST_S1(RLAST_S1),
    .RREADY_M0(RREADY_M0), .RREADY_M1(RREADY_M1),
    .RREADY_S0(RREADY_S0), .RREADY_S1(RREADY_S1),
    .CS_R(CS_R), .NS_R(NS_R),
    .DEF_RID(DEF_RID), .DEF_RRESP(DEF_RRESP),
    .DEF_RVALID(DEF_RVALID), .DEF_RLAST(DEF_RLAST)
  );

  // State codes from the published read-state table.
  function automatic logic [3:0] ra_code(input int m);
    return (m == 1) ? 4'd1 : 4'd4;
  endfunction
  function automatic logic [3:0] rd_code(input int m, input int s);
    return (m == 1) ? 4'(2 + s) : 4'(5 + s);
  endfunction
  function automatic logic arready_m(input int m);
    return (m == 1) ? ARREADY_M1 : ARREADY_M0;
  endfunction
  function automatic logic arvalid_s(input int s);
    return (s == 1) ? ARVALID_S1 : ARVALID_S0;
  endfunction
  function automatic logic rready_s(input int s);
    return (s == 1) ? RREADY_S1 : RREADY_S0;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    ARVALID_M0 = 0; ARVALID_M1 = 0; ARADDR_M0 = 0; ARADDR_M1 = 0;
    ARID_M0 = 0; ARID_M1 = 0; ARLEN_M0 = 0; ARLEN_M1 = 0;
    ARREADY_S0 = 0; ARREADY_S1 = 0; RVALID_S0 = 0; RVALID_S1 = 0;
    RLAST_S0 = 0; RLAST_S1 = 0; RREADY_M0 = 0; RREADY_M1 = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    ARESETn = 0;
    tick();
    ARESETn = 1;
  endtask

  task automatic set_m(input int m, input logic v, input logic [31:0] a,
                       input logic [3:0] id, input logic [3:0] len);
    if (m == 1) begin ARVALID_M1 = v; ARADDR_M1 = a; ARID_M1 = id; ARLEN_M1 = len; end
    else        begin ARVALID_M0 = v; ARADDR_M0 = a; ARID_M0 = id; ARLEN_M0 = len; end
  endtask

  task automatic set_rready(input int m, input logic v);
    if (m == 1) RREADY_M1 = v; else RREADY_M0 = v;
  endtask

  task automatic set_arready_s(input int s, input logic v);
    if (s == 1) ARREADY_S1 = v; else ARREADY_S0 = v;
  endtask

  task automatic set_slave(input int s, input logic v, input logic last);
    if (s == 1) begin RVALID_S1 = v; RLAST_S1 = last; end
    else        begin RVALID_S0 = v; RLAST_S0 = last; end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (CS_R !== 4'd0) begin failures++; $display("FAIL reset_cs got=%0d exp=0", CS_R); end
    checks++; if ({ARREADY_M0, ARREADY_M1, ARVALID_S0, ARVALID_S1, RREADY_S0, RREADY_S1, DEF_RVALID} !== 7'b0)
      begin failures++; $display("FAIL reset_outputs got=%b exp=0", {ARREADY_M0, ARREADY_M1, ARVALID_S0, ARVALID_S1, RREADY_S0, RREADY_S1, DEF_RVALID}); end
    ARVALID_M0 = 1; ARVALID_M1 = 1; RREADY_M0 = 1; RREADY_M1 = 1;
    #1;
    checks++; if (NS_R !== 4'd4) begin failures++; $display("FAIL reset_first_grant ns got=%0d exp=4", NS_R); end
    checks++; if ({ARREADY_M0, ARREADY_M1, RREADY_S0, RREADY_S1} !== 4'b0)
      begin failures++; $display("FAIL idle_outputs got=%b exp=0", {ARREADY_M0, ARREADY_M1, RREADY_S0, RREADY_S1}); end
  endtask

  task automatic test_m0_s0_single();
    apply_reset();
    set_m(0, 1, 32'h0000_0040, 4'h2, 4'h0);
    ARREADY_S0 = 1;
    #1;
    checks++; if (NS_R !== 4'd4) begin failures++; $display("FAIL single_ns_idle got=%0d exp=4", NS_R); end
    tick();
    checks++; if (CS_R !== 4'd4) begin failures++; $display("FAIL single_cs_ra got=%0d exp=4", CS_R); end
    checks++; if ({ARVALID_S0, ARVALID_S1, ARREADY_M0} !== 3'b101)
      begin failures++; $display("FAIL single_ar_route got=%b exp=101", {ARVALID_S0, ARVALID_S1, ARREADY_M0}); end
    tick();
    idle_inputs();
    #1;
    checks++; if (CS_R !== 4'd5) begin failures++; $display("FAIL single_cs_rd got=%0d exp=5", CS_R); end
    RVALID_S0 = 1; RLAST_S0 = 1; RREADY_M0 = 1; ARREADY_S0 = 1;
    #1;
    checks++; if ({ARVALID_S0, ARVALID_S1, RREADY_S0, RREADY_S1} !== 4'b0010)
      begin failures++; $display("FAIL single_data_route got=%b exp=0010", {ARVALID_S0, ARVALID_S1, RREADY_S0, RREADY_S1}); end
    tick();
    idle_inputs();
    #1;
    checks++; if (CS_R !== 4'd0) begin failures++; $display("FAIL single_cs_end got=%0d exp=0", CS_R); end
  endtask

  task automatic test_round_robin();
    int last_g;
    int g;
    apply_reset();
    last_g = 1;
    set_m(0, 1, 32'h0001_0010, 4'h1, 4'h0);
    set_m(1, 1, 32'h0001_0020, 4'h2, 4'h0);
    ARREADY_S1 = 1;
    for (int n = 0; n < 3; n++) begin
      g = (last_g == 1) ? 0 : 1;
      RVALID_S1 = 0; RLAST_S1 = 0; RREADY_M0 = 0; RREADY_M1 = 0;
      #1;
      checks++; if (NS_R !== ra_code(g)) begin failures++; $display("FAIL rr_ns_grant%0d got=%0d exp=%0d", n, NS_R, ra_code(g)); end
      tick();
      checks++; if (CS_R !== ra_code(g)) begin failures++; $display("FAIL rr_cs_ra%0d got=%0d exp=%0d", n, CS_R, ra_code(g)); end
      checks++; if (arready_m(1 - g) !== 1'b0) begin failures++; $display("FAIL rr_loser_arready%0d got=%b exp=0", n, arready_m(1 - g)); end
      tick();
      checks++; if (CS_R !== rd_code(g, 1)) begin failures++; $display("FAIL rr_cs_rd%0d got=%0d exp=%0d", n, CS_R, rd_code(g, 1)); end
      RVALID_S1 = 1; RLAST_S1 = 1; set_rready(g, 1);
      #1;
      checks++; if (RREADY_S1 !== 1'b1) begin failures++; $display("FAIL rr_rready%0d got=%b exp=1", n, RREADY_S1); end
      tick();
      checks++; if (CS_R !== 4'd0) begin failures++; $display("FAIL rr_cs_end%0d got=%0d exp=0", n, CS_R); end
      last_g = g;
    end
  endtask

  task automatic test_default_slave();
    int beats;
    apply_reset();
    set_m(1, 1, 32'h0005_0000, 4'hA, 4'd3);
    tick();
    checks++; if ({ARREADY_M1, ARVALID_S0, ARVALID_S1} !== 3'b100)
      begin failures++; $display("FAIL def_ar got=%b exp=100", {ARREADY_M1, ARVALID_S0, ARVALID_S1}); end
    checks++; if (NS_R !== 4'd13) begin failures++; $display("FAIL def_ns got=%0d exp=13", NS_R); end
    tick();
    idle_inputs();
    beats = 0;
    for (int c = 0; c < 200 && beats < 4; c++) begin
      RREADY_M1 = 1'($urandom_range(0, 1));
      #1;
      checks++; if ({DEF_RVALID, DEF_RRESP, DEF_RID} !== {1'b1, 2'b11, 8'h1A})
        begin failures++; $display("FAIL def_beat got=%b/%b/%h exp=1/11/1a", DEF_RVALID, DEF_RRESP, DEF_RID); end
      checks++; if (DEF_RLAST !== (beats == 3)) begin failures++; $display("FAIL def_rlast beat%0d got=%b exp=%b", beats, DEF_RLAST, beats == 3); end
      if (RREADY_M1) beats++;
      tick();
    end
    RREADY_M1 = 0;
    #1;
    checks++; if (beats != 4) begin failures++; $display("FAIL def_timeout beats got=%0d exp=4", beats); end
    checks++; if ({CS_R, DEF_RVALID} !== 5'b0) begin failures++; $display("FAIL def_end got=%0d/%b exp=0/0", CS_R, DEF_RVALID); end
  endtask

  task automatic test_ar_stall();
    apply_reset();
    set_m(0, 1, 32'h0000_1000, 4'h7, 4'h0);
    ARREADY_S0 = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({CS_R, ARREADY_M0, ARVALID_S0} !== {4'd4, 1'b0, 1'b1})
        begin failures++; $display("FAIL stall%0d got=%0d/%b/%b exp=4/0/1", i, CS_R, ARREADY_M0, ARVALID_S0); end
      tick();
    end
    ARREADY_S0 = 1;
    #1;
    checks++; if (ARREADY_M0 !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", ARREADY_M0); end
    tick();
    idle_inputs();
    #1;
    checks++; if (CS_R !== 4'd5) begin failures++; $display("FAIL stall_cs_rd got=%0d exp=5", CS_R); end
    RVALID_S0 = 1; RLAST_S0 = 1; RREADY_M0 = 1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    // Complete one M0 transaction so the round-robin would favour M1 without a reset.
    set_m(0, 1, 32'h0000_0100, 4'h3, 4'h0);
    ARREADY_S0 = 1;
    tick(); tick();
    idle_inputs();
    RVALID_S0 = 1; RLAST_S0 = 1; RREADY_M0 = 1;
    tick();
    idle_inputs();
    set_m(1, 1, 32'h0001_0020, 4'h5, 4'h7);
    ARREADY_S1 = 1;
    tick(); tick();
    idle_inputs();
    RVALID_S1 = 1; RLAST_S1 = 0; RREADY_M1 = 1;
    tick(); tick();
    checks++; if ({CS_R, RREADY_S1} !== {4'd3, 1'b1}) begin failures++; $display("FAIL midburst_cs got=%0d/%b exp=3/1", CS_R, RREADY_S1); end
    ARESETn = 0;
    tick();
    checks++; if ({CS_R, RREADY_S1} !== {4'd0, 1'b0}) begin failures++; $display("FAIL midburst_reset got=%0d/%b exp=0/0", CS_R, RREADY_S1); end
    ARESETn = 1;
    idle_inputs();
    set_m(0, 1, 32'h0000_0200, 4'h1, 4'h0);
    set_m(1, 1, 32'h0001_0200, 4'h2, 4'h0);
    #1;
    checks++; if (NS_R !== 4'd4) begin failures++; $display("FAIL midburst_regrant got=%0d exp=4", NS_R); end
    tick();
    checks++; if (CS_R !== 4'd4) begin failures++; $display("FAIL midburst_cs_ra got=%0d exp=4", CS_R); end
  endtask

  task automatic test_default_len15();
    int beats;
    logic [3:0] id;
    apply_reset();
    id = 4'($urandom);
    set_m(0, 1, 32'hABCD_0000, id, 4'd15);
    tick(); tick();
    idle_inputs();
    RREADY_M0 = 1;
    beats = 0;
    for (int b = 1; b <= 16; b++) begin
      #1;
      checks++; if ({DEF_RVALID, DEF_RID} !== {1'b1, 4'h0, id})
        begin failures++; $display("FAIL len15_beat%0d got=%b/%h exp=1/%h", b, DEF_RVALID, DEF_RID, {4'h0, id}); end
      checks++; if (DEF_RLAST !== (b == 16)) begin failures++; $display("FAIL len15_rlast%0d got=%b exp=%b", b, DEF_RLAST, b == 16); end
      beats++;
      tick();
    end
    RREADY_M0 = 0;
    #1;
    checks++; if ({CS_R, DEF_RVALID} !== 5'b0) begin failures++; $display("FAIL len15_end beats=%0d got=%0d/%b exp=0/0", beats, CS_R, DEF_RVALID); end
  endtask

  task automatic test_random();
    int last_g, g, k, beats, d;
    logic [1:0]  req;
    logic [31:0] a [2];
    logic [3:0]  ids [2];
    logic [3:0]  lens [2];
    int          region [2];
    logic        rv, rr;
    apply_reset();
    last_g = 1;
    for (int it = 0; it < 40; it++) begin
      idle_inputs();
      req = 2'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++) begin
        region[m] = $urandom_range(0, 2);
        ids[m]    = 4'($urandom);
        lens[m]   = 4'($urandom_range(0, 5));
        if (region[m] == 0)      a[m] = {S0B, 16'($urandom)};
        else if (region[m] == 1) a[m] = {S1B, 16'($urandom)};
        else                     a[m] = {16'($urandom_range(2, 65535)), 16'($urandom)};
        set_m(m, req[m], a[m], ids[m], lens[m]);
      end
      g = (req == 2'b11) ? ((last_g == 1) ? 0 : 1) : ((req == 2'b01) ? 0 : 1);
      k = region[g];
      #1;
      checks++; if ({CS_R, NS_R} !== {4'd0, ra_code(g)}) begin failures++; $display("FAIL rnd%0d_arb got=%0d/%0d exp=0/%0d", it, CS_R, NS_R, ra_code(g)); end
      tick();
      checks++; if ({CS_R, arready_m(1 - g)} !== {ra_code(g), 1'b0}) begin failures++; $display("FAIL rnd%0d_ra got=%0d/%b exp=%0d/0", it, CS_R, arready_m(1 - g), ra_code(g)); end
      if (k < 2) begin
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin
          #1;
          checks++; if ({arready_m(g), arvalid_s(k), arvalid_s(1 - k)} !== 3'b010)
            begin failures++; $display("FAIL rnd%0d_stall got=%b exp=010", it, {arready_m(g), arvalid_s(k), arvalid_s(1 - k)}); end
          tick();
        end
        set_arready_s(k, 1);
        #1;
        checks++; if (arready_m(g) !== 1'b1) begin failures++; $display("FAIL rnd%0d_hs got=%b exp=1", it, arready_m(g)); end
        tick();
        idle_inputs();
        beats = 0;
        for (int c = 0; c < 300 && beats <= int'(lens[g]); c++) begin
          rv = 1'($urandom_range(0, 1));
          rr = 1'($urandom_range(0, 1));
          set_slave(k, rv, rv && (beats == int'(lens[g])));
          set_rready(g, rr);
          #1;
          checks++; if ({CS_R, rready_s(k), rready_s(1 - k)} !== {rd_code(g, k), rr, 1'b0})
            begin failures++; $display("FAIL rnd%0d_data got=%0d/%b/%b exp=%0d/%b/0", it, CS_R, rready_s(k), rready_s(1 - k), rd_code(g, k), rr); end
          if (rv && rr) beats++;
          tick();
        end
      end else begin
        #1;
        checks++; if ({arready_m(g), ARVALID_S0, ARVALID_S1, NS_R} !== {3'b100, 4'd13})
          begin failures++; $display("FAIL rnd%0d_def_ar got=%b/%0d exp=100/13", it, {arready_m(g), ARVALID_S0, ARVALID_S1}, NS_R); end
        tick();
        idle_inputs();
        beats = 0;
        for (int c = 0; c < 300 && beats <= int'(lens[g]); c++) begin
          rr = 1'($urandom_range(0, 1));
          set_rready(g, rr);
          #1;
          checks++; if ({DEF_RVALID, DEF_RRESP, DEF_RID, DEF_RLAST} !== {1'b1, 2'b11, 4'(g), ids[g], beats == int'(lens[g])})
            begin failures++; $display("FAIL rnd%0d_def got=%b/%b/%h/%b exp=1/11/%h/%b", it, DEF_RVALID, DEF_RRESP, DEF_RID, DEF_RLAST, {4'(g), ids[g]}, beats == int'(lens[g])); end
          if (rr) beats++;
          tick();
        end
      end
      idle_inputs();
      #1;
      checks++; if ({CS_R, beats} !== {4'd0, int'(lens[g]) + 1})
        begin failures++; $display("FAIL rnd%0d_end got=%0d beats=%0d exp=0 beats=%0d", it, CS_R, beats, int'(lens[g]) + 1); end
      last_g = g;
    end
  endtask

  initial begin
    test_reset();
    test_m0_s0_single();
    test_round_robin();
    test_default_slave();
    test_ar_stall();
    test_reset_mid_burst();
    test_default_len15();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Read-channel controller for the 2-master / 2-slave AXI interconnect.
- Arbitrates AR requests from M0 and M1 using round-robin, and decodes ARADDR[31:16] to S0, S1 or the default slave.
- Sequences address and data phases and drives the 4-bit read-state code (CS_R/NS_R) consumed by the S2M read mux.
- Also acts as the default slave itself, returning DECERR beats for unmapped addresses.

Parameters:
- S0_BASE, 16'h0000, ARADDR[31:16] value decoding to slave 0
- S1_BASE, 16'h0001, ARADDR[31:16] value decoding to slave 1

Ports:
- ACLK  in  1  clock; all state updates on rising edge
- ARESETn  in  1  reset, synchronous active-low
- ARVALID_M0 / ARVALID_M1  in  1  master address valid
- ARADDR_M0 / ARADDR_M1  in  32  master read address
- ARID_M0 / ARID_M1  in  4  master transaction ID
- ARLEN_M0 / ARLEN_M1  in  4  burst length minus 1
- ARREADY_M0 / ARREADY_M1  out  1  address ready to masters
- ARVALID_S0 / ARVALID_S1  out  1  routed address valid to slaves
- ARREADY_S0 / ARREADY_S1  in  1  slave address ready
- RVALID_S0 / RVALID_S1, RLAST_S0 / RLAST_S1  in  1  slave read-data status
- RREADY_M0 / RREADY_M1  in  1  master data ready
- RREADY_S0 / RREADY_S1  out  1  routed data ready to slaves
- CS_R  out  4  current read state code
- NS_R  out  4  next read state code (combinational)
- DEF_RID  out  8  default-slave RID, {4'(master index), ARID}
- DEF_RRESP  out  2  default-slave response
- DEF_RVALID / DEF_RLAST  out  1  default-slave beat valid / last

Behaviour:
- State codes are fixed:
  - IDLE=0, ReadAddr_M1=1, ReadData_M1S0=2, ReadData_M1S1=3
  - ReadAddr_M0=4, ReadData_M0S0=5, ReadData_M0S1=6, Default_Slave=13
  - All other codes are unreachable; if entered, return to IDLE next cycle.
- Reset (ARESETn=0 at an ACLK edge): CS_R=IDLE, last_grant=M1 (so M0 wins first), beat counter=0, latched len/ID=0. This applies from any state, including mid-burst.
- Outputs while in IDLE: all ARREADY_*, ARVALID_S*, RREADY_S* and DEF_RVALID are 0.
- Combinational outputs: ARREADY_M*, ARVALID_S*, RREADY_S*, NS_R. Registered: CS_R, counter, latched fields.
- IDLE transitions:
  - Only one ARVALID high -> ReadAddr of that master.
  - Both high -> ReadAddr of the master that is not last_grant.
  - Neither high -> stay in IDLE.
- ReadAddr_Mx, decode of ARADDR_Mx[31:16]:
  - ==S0_BASE: ARVALID_S0=ARVALID_Mx, ARREADY_Mx=ARREADY_S0. On handshake -> ReadData_MxS0.
  - ==S1_BASE: the same with S1 -> ReadData_MxS1.
  - Unmapped: ARREADY_Mx=1 for this cycle; latch ARID, ARLEN and master index; clear counter; -> Default_Slave. No slave sees ARVALID.
  - ARVALID_Mx low (protocol violation): -> IDLE, no grant update.
- Address-phase latency:
  - Minimum 1 cycle in IDLE plus 1 cycle in ReadAddr.
  - Data state is entered on the edge after the AR handshake.
- ReadData_MxSk:
  - RREADY_Sk=RREADY_Mx; the other slave's RREADY is 0.
  - Stay until RVALID_Sk & RREADY_Mx & RLAST_Sk, then -> IDLE and last_grant=x.
  - Non-last beats do not change state.
- Default_Slave:
  - DEF_RVALID=1, DEF_RRESP=2'b11 (DECERR), DEF_RID=latched value.
  - DEF_RLAST=(counter==latched ARLEN).
  - Counter increments on each RREADY_Mx. On RREADY_Mx with DEF_RLAST -> IDLE and last_grant=x.
  - Beats returned = ARLEN+1; ARLEN=15 returns 16 beats; the 4-bit counter must not wrap.
- The non-granted master's ARREADY stays 0 throughout; its request is serviced in the next arbitration.
- Exactly one transaction is outstanding; no new AR is accepted until the last beat completes.

Test Plan:
1. M0 only, ARADDR=0x0000_0040, ARREADY_S0=1, single beat with RLAST -> CS_R sequence 0,4,5,0; ARVALID_S0 high for 1 cycle; ARVALID_S1 never asserted.
2. M0 and M1 both request S1 back-to-back after reset -> M0 granted first (CS_R 4,6); after its RLAST, M1 granted (1,3); with both still requesting, the third grant goes to M0.
3. M1, ARADDR=0x0005_0000, ARLEN=3, ARID=4'hA, RREADY_M1 toggling -> CS_R=13; four DEF_RVALID beats with RRESP=11 and DEF_RID=8'h1A; DEF_RLAST only on the 4th accepted beat; then IDLE.
4. M0 to S0, ARREADY_S0 held low 5 cycles -> CS_R stays 4 with ARREADY_M0=0 until ARREADY_S0=1; then 5 next cycle.
5. Reset asserted mid-burst in ReadData_M1S1 -> CS_R=0 on the next edge; RREADY_S1=0; next simultaneous request grants M0.
6. Default slave with ARLEN=15 and RREADY_M0 held high -> exactly 16 beats; DEF_RLAST on beat 16; no counter wrap.
